// File: rtl/decouple_event_monitor.sv
// Purpose: per-channel decouple line monitor. Each channel produces a mode-selected
// edge capture pulse, a sticky event/overflow flag pair and a saturating high-duration
// measurement that can be read back through a registered channel mux.
// Ports:
//   clk, resetn        single clock, synchronous active-low reset
//   din                decouple inputs, one bit per channel
//   mode               per-channel edge mode (00 fall, 01 rise, 10 both, 11 off)
//   capture            one-cycle pulse per selected edge
//   flag, ovf          sticky event and overflow flags
//   flag_clr           per-channel clear of flag and ovf
//   rd_sel             channel select for readback
//   rd_dur, rd_busy    last completed high duration / line currently high
module decouple_event_monitor #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 0,
  parameter int unsigned DUR_W       = 16,
  parameter int unsigned SEL_W       = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_CH-1:0]   din,
  input  logic [2*NUM_CH-1:0] mode,
  output logic [NUM_CH-1:0]   capture,
  output logic [NUM_CH-1:0]   flag,
  output logic [NUM_CH-1:0]   ovf,
  input  logic [NUM_CH-1:0]   flag_clr,
  input  logic [SEL_W-1:0]    rd_sel,
  output logic [DUR_W-1:0]    rd_dur,
  output logic                rd_busy
);

  logic [NUM_CH-1:0] din_s;
  logic [NUM_CH-1:0] prev;
  logic [NUM_CH-1:0] primed;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic [NUM_CH-1:0] event_hit;
  logic [DUR_W-1:0]  cnt     [NUM_CH];
  logic [DUR_W-1:0]  dur_lat [NUM_CH];
  logic [DUR_W-1:0]  rd_dur_nxt;
  logic              rd_busy_nxt;

  // Optional input synchroniser chain
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign din_s = din;
    end else begin : g_sync
      logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk) begin
        if (!resetn) begin
          for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= din;
          for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign din_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Edge detect and per-channel mode selection. A channel is primed only once its
  // line has been seen low after reset, so a pulse straddling reset release (rise
  // and fall alike) is ignored.
  always_comb begin
    rise      = din_s & ~prev & primed;
    fall      = ~din_s & prev & primed;
    event_hit = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      case (mode[2*i +: 2])
        2'b00:   event_hit[i] = fall[i];
        2'b01:   event_hit[i] = rise[i];
        2'b10:   event_hit[i] = rise[i] | fall[i];
        default: event_hit[i] = 1'b0;
      endcase
    end
  end

  // Readback mux; out-of-range selects read as zero
  always_comb begin
    rd_dur_nxt  = '0;
    rd_busy_nxt = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_dur_nxt  = dur_lat[i];
        rd_busy_nxt = din_s[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      prev    <= '0;
      primed  <= '0;
      capture <= '0;
      flag    <= '0;
      ovf     <= '0;
      rd_dur  <= '0;
      rd_busy <= 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        cnt[i]     <= '0;
        dur_lat[i] <= '0;
      end
    end else begin
      prev    <= din_s;
      primed  <= primed | ~din_s;
      capture <= event_hit;
      rd_dur  <= rd_dur_nxt;
      rd_busy <= rd_busy_nxt;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        // An event beats a simultaneous clear; the clear still drops the old overflow
        if (event_hit[i]) begin
          flag[i] <= 1'b1;
          ovf[i]  <= ~flag_clr[i] & (ovf[i] | flag[i]);
        end else if (flag_clr[i]) begin
          flag[i] <= 1'b0;
          ovf[i]  <= 1'b0;
        end
        // Non-zero cnt marks a measurement in progress
        if (rise[i]) begin
          cnt[i] <= DUR_W'(1);
        end else if (din_s[i]) begin
          if (cnt[i] != '0 && cnt[i] != '1) cnt[i] <= cnt[i] + DUR_W'(1);
        end else if (cnt[i] != '0) begin
          dur_lat[i] <= cnt[i];
          cnt[i]     <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_decouple_event_monitor.sv
// Directed bench: dut0 uses the default parameters, dut1 has a two-stage
// synchroniser and a 4-bit duration counter.
module tb_decouple_event_monitor;

  logic        clk;
  logic        resetn;

  logic [3:0]  din0, flag_clr0, capture0, flag0, ovf0;
  logic [7:0]  mode0;
  logic [3:0]  rd_sel0;
  logic [15:0] rd_dur0;
  logic        rd_busy0;

  logic [3:0]  din1, flag_clr1, capture1, flag1, ovf1;
  logic [7:0]  mode1;
  logic [3:0]  rd_sel1;
  logic [3:0]  rd_dur1;
  logic        rd_busy1;

  int checks = 0;
  int errors = 0;

  decouple_event_monitor #(.NUM_CH(4), .SYNC_STAGES(0), .DUR_W(16), .SEL_W(4)) dut0 (
    .clk(clk), .resetn(resetn), .din(din0), .mode(mode0), .capture(capture0),
    .flag(flag0), .ovf(ovf0), .flag_clr(flag_clr0), .rd_sel(rd_sel0),
    .rd_dur(rd_dur0), .rd_busy(rd_busy0)
  );

  decouple_event_monitor #(.NUM_CH(4), .SYNC_STAGES(2), .DUR_W(4), .SEL_W(4)) dut1 (
    .clk(clk), .resetn(resetn), .din(din1), .mode(mode1), .capture(capture1),
    .flag(flag1), .ovf(ovf1), .flag_clr(flag_clr1), .rd_sel(rd_sel1),
    .rd_dur(rd_dur1), .rd_busy(rd_busy1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk       = 1'b0;
    resetn    = 1'b0;
    din0      = 4'b1000;
    mode0     = 8'b00_11_10_00;
    flag_clr0 = '0;
    rd_sel0   = 4'd3;
    din1      = '0;
    mode1     = 8'b11_11_11_01;
    flag_clr1 = '0;
    rd_sel1   = 4'd2;
    tick();
    tick();

    // Reset values
    check("rst_capture", 32'(capture0), 32'd0);
    check("rst_flag",    32'(flag0),    32'd0);
    check("rst_ovf",     32'(ovf0),     32'd0);
    check("rst_rd_dur",  32'(rd_dur0),  32'd0);
    check("rst_rd_busy", 32'(rd_busy0), 32'd0);

    // Line high through reset release, then falls: no event, no duration
    resetn = 1'b1;
    tick(); tick(); tick();
    check("t5_busy_high", 32'(rd_busy0), 32'd1);
    din0[3] = 1'b0;
    tick();
    check("t5_no_capture", 32'(capture0[3]), 32'd0);
    check("t5_no_flag",    32'(flag0[3]),    32'd0);
    tick();
    check("t5_no_ovf",     32'(ovf0[3]),     32'd0);
    check("t5_dur_zero",   32'(rd_dur0),     32'd0);
    check("t5_busy_low",   32'(rd_busy0),    32'd0);

    // Fall mode on ch0, 10-cycle pulse
    rd_sel0 = 4'd0;
    din0[0] = 1'b1;
    tick();
    check("t1_no_cap_rise", 32'(capture0[0]), 32'd0);
    check("t1_busy",        32'(rd_busy0),    32'd1);
    repeat (9) tick();
    din0[0] = 1'b0;
    tick();
    check("t1_capture", 32'(capture0[0]), 32'd1);
    check("t1_flag",    32'(flag0[0]),    32'd1);
    tick();
    check("t1_cap_once", 32'(capture0[0]), 32'd0);
    check("t1_rd_dur",   32'(rd_dur0),     32'd10);
    check("t1_busy_low", 32'(rd_busy0),    32'd0);

    // Out-of-range select
    rd_sel0 = 4'd4;
    tick();
    check("oor_rd_dur",  32'(rd_dur0),  32'd0);
    check("oor_rd_busy", 32'(rd_busy0), 32'd0);
    rd_sel0 = 4'd0;
    tick();
    check("sel_back", 32'(rd_dur0), 32'd10);

    // Both-edge mode on ch1, 3-cycle pulse
    din0[1] = 1'b1;
    tick();
    check("t2_cap_rise", 32'(capture0[1]), 32'd1);
    check("t2_flag1",    32'(flag0[1]),    32'd1);
    check("t2_ovf0",     32'(ovf0[1]),     32'd0);
    tick();
    check("t2_cap_gap", 32'(capture0[1]), 32'd0);
    tick();
    din0[1] = 1'b0;
    tick();
    check("t2_cap_fall", 32'(capture0[1]), 32'd1);
    check("t2_flag2",    32'(flag0[1]),    32'd1);
    check("t2_ovf1",     32'(ovf0[1]),     32'd1);
    flag_clr0[1] = 1'b1;
    tick();
    flag_clr0 = '0;
    check("t2_clr_flag", 32'(flag0[1]), 32'd0);
    check("t2_clr_ovf",  32'(ovf0[1]),  32'd0);
    check("t2_ch0_kept", 32'(flag0[0]), 32'd1);

    // Event and clear together with flag already set
    din0[1] = 1'b1;
    tick();
    check("t3_flag_set", 32'(flag0[1]), 32'd1);
    din0[1]      = 1'b0;
    flag_clr0[1] = 1'b1;
    tick();
    flag_clr0 = '0;
    check("t3_flag", 32'(flag0[1]),    32'd1);
    check("t3_ovf",  32'(ovf0[1]),     32'd0);
    check("t3_cap",  32'(capture0[1]), 32'd1);

    // Mode change alone produces no event
    mode0[3:2] = 2'b01;
    tick();
    check("mode_chg_nocap", 32'(capture0), 32'd0);

    // Synchronised rise mode on dut1 ch0: capture 3 clocks after din
    rd_sel1 = 4'd0;
    din1[0] = 1'b1;
    tick();
    check("t6_cap_d1", 32'(capture1[0]), 32'd0);
    tick();
    check("t6_cap_d2", 32'(capture1[0]), 32'd0);
    tick();
    check("t6_cap_d3", 32'(capture1[0]), 32'd1);
    check("t6_flag",   32'(flag1[0]),    32'd1);
    tick();
    check("t6_cap_d4", 32'(capture1[0]), 32'd0);
    tick(); tick();
    din1[0] = 1'b0;
    repeat (4) tick();
    check("t6_dur6",  32'(rd_dur1),  32'd6);
    check("t6_busy0", 32'(rd_busy1), 32'd0);

    // Disabled mode still measures duration
    mode1[1:0] = 2'b11;
    din1[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t6_off_nocap", 32'(capture1[0]), 32'd0);
    end
    din1[0] = 1'b0;
    repeat (4) tick();
    check("t6_off_dur5",   32'(rd_dur1),     32'd5);
    check("t6_off_nocap2", 32'(capture1[0]), 32'd0);

    // 40-cycle pulse saturates the 4-bit counter
    rd_sel1 = 4'd2;
    din1[2] = 1'b1;
    repeat (3) tick();
    check("t4_busy", 32'(rd_busy1), 32'd1);
    repeat (37) tick();
    check("t4_busy_late", 32'(rd_busy1), 32'd1);
    din1[2] = 1'b0;
    repeat (4) tick();
    check("t4_dur_sat", 32'(rd_dur1),  32'd15);
    check("t4_busy_end", 32'(rd_busy1), 32'd0);
    check("t4_no_cap",  32'(capture1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
